// File: rtl/seq_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mux_scan
//  Description : N-channel, W-bit registered multiplexer with two modes.
//                DIRECT routes the channel named by sel. SCAN routes the
//                channel named by an internal pointer that can be loaded or
//                stepped round-robin, with a one-cycle wrap pulse.
//                Optional macro SEQ_MUX_SCAN_HOLD_EN adds a hold input that
//                freezes the pointer, the outputs and the mode edge detector.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mux_scan #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic                load,
    input  logic                step_en,
`ifdef SEQ_MUX_SCAN_HOLD_EN
    input  logic                hold,
`endif
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic [SEL_W-1:0]    out_ch,
    output logic                wrap
);

    // Every select code gets a slot; codes past the last real channel read
    // as zero, so out-of-range selects need no extra masking downstream.
    localparam int               c_n_slots = 1 << SEL_W;
    localparam logic [SEL_W:0]   c_n_ch    = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] c_last    = SEL_W'(N_CH - 1);

    logic [W-1:0]     w_chan [c_n_slots];
    logic             w_hold;
    logic             w_sel_ok;
    logic [SEL_W-1:0] w_sel_clamp;
    logic             w_ptr_last;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_mode_rise;

    logic [SEL_W-1:0] r_ptr;
    logic             r_mode_q;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_wrap;

    // Unpack the flat input bus into per-slot channel words.
    generate
        for (genvar c = 0; c < c_n_slots; c++) begin : g_ch
            if (c < N_CH) begin : g_used
                assign w_chan[c] = in_data[c*W +: W];
            end else begin : g_unused
                assign w_chan[c] = '0;
            end
        end
    endgenerate

`ifdef SEQ_MUX_SCAN_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_sel_ok    = ({1'b0, sel} < c_n_ch);
    assign w_sel_clamp = w_sel_ok ? sel : '0;
    assign w_ptr_last  = (r_ptr == c_last);
    assign w_ptr_next  = w_ptr_last ? '0 : r_ptr + SEL_W'(1);
    assign w_mode_rise = mode & ~r_mode_q;

    // Scan pointer, mode edge detector and wrap pulse; only SCAN moves the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_mode_q <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (w_hold) begin
            r_wrap   <= 1'b0;
        end else begin
            r_mode_q <= mode;
            r_wrap   <= 1'b0;
            if (mode) begin
                // Entering SCAN and load both restart from sel; load beats step.
                if (w_mode_rise || load) begin
                    r_ptr <= w_sel_clamp;
                end else if (step_en) begin
                    r_ptr  <= w_ptr_next;
                    r_wrap <= w_ptr_last;
                end
            end
        end
    end

    // Output register: SCAN reports the pointer value held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (!w_hold) begin
            if (mode) begin
                r_out_data  <= w_chan[r_ptr];
                r_out_valid <= 1'b1;
                r_out_ch    <= r_ptr;
            end else begin
                r_out_data  <= w_chan[sel];
                r_out_valid <= w_sel_ok;
                r_out_ch    <= sel;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire
